// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared defaults, address-width helper and data word type for the vector register file
package vrf_pkg;

    localparam int VRF_DATA_W = 512;
    localparam int VRF_DEPTH  = 4;

    typedef logic [VRF_DATA_W-1:0] vrf_word_t;

    function automatic int vrf_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vrf_read_port.sv
// rtl/vrf_read_port.sv - one registered read port: range check, write bypass, pending check
module vrf_read_port
    import vrf_pkg::*;
#(
    parameter int DATA_W = VRF_DATA_W,
    parameter int DEPTH  = VRF_DEPTH,
    parameter int ADDR_W = vrf_clog2(VRF_DEPTH),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_mem,
    input  logic [DEPTH-1:0]  pend,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic in_range;
    logic hit0;
    logic hit1;
    logic pend_hit;

    assign in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
    assign hit0     = (BYPASS != 0) && wr0_en && (wr0_addr == rd_addr);
    assign hit1     = (BYPASS != 0) && wr1_en && (wr1_addr == rd_addr);

    always_comb begin
        pend_hit = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            if (rd_addr == ADDR_W'(r)) begin
                pend_hit = pend[r];
            end
        end
    end

    // Pending without a bypass hit keeps the last delivered word on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (!rd_en) begin
            rd_valid <= 1'b0;
        end else if (!in_range) begin
            rd_data  <= '0;
            rd_valid <= 1'b1;
        end else if (hit1) begin
            rd_data  <= wr1_data;
            rd_valid <= 1'b1;
        end else if (hit0) begin
            rd_data  <= wr0_data;
            rd_valid <= 1'b1;
        end else if (!pend_hit) begin
            rd_data  <= rd_mem;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vector_reg_file.sv
// rtl/vector_reg_file.sv - two-read/two-write vector register file with pending scoreboard
module vector_reg_file
    import vrf_pkg::*;
#(
    parameter int  DATA_W = VRF_DATA_W,
    parameter int  DEPTH  = VRF_DEPTH,
    parameter int  BYPASS = 1,
    localparam int ADDR_W = vrf_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_valid,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_err,
    output logic [DEPTH-1:0]  pend
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend_next;
    logic              rsv_hit_pend;
    logic [DATA_W-1:0] rd0_mem;
    logic [DATA_W-1:0] rd1_mem;

    // A reservation beats a same-cycle write: that write retires the previous producer.
    always_comb begin
        pend_next    = pend;
        rsv_hit_pend = 1'b0;
        rd0_mem      = '0;
        rd1_mem      = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (rsv_en && (rsv_addr == ADDR_W'(r))) begin
                pend_next[r] = 1'b1;
                rsv_hit_pend = pend[r];
            end else if ((wr0_en && (wr0_addr == ADDR_W'(r))) ||
                         (wr1_en && (wr1_addr == ADDR_W'(r)))) begin
                pend_next[r] = 1'b0;
            end
            if (rd0_addr == ADDR_W'(r)) begin
                rd0_mem = mem[r];
            end
            if (rd1_addr == ADDR_W'(r)) begin
                rd1_mem = mem[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
            pend    <= '0;
            rsv_err <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (wr0_en && (wr0_addr == ADDR_W'(r))) begin
                    mem[r] <= wr0_data;
                end
                if (wr1_en && (wr1_addr == ADDR_W'(r))) begin
                    mem[r] <= wr1_data;
                end
            end
            pend    <= pend_next;
            rsv_err <= rsv_hit_pend;
        end
    end

    vrf_read_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd0 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd0_en),
        .rd_addr  (rd0_addr),
        .rd_mem   (rd0_mem),
        .pend     (pend),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .rd_data  (rd0_data),
        .rd_valid (rd0_valid)
    );

    vrf_read_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd1 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd1_en),
        .rd_addr  (rd1_addr),
        .rd_mem   (rd1_mem),
        .pend     (pend),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .rd_data  (rd1_data),
        .rd_valid (rd1_valid)
    );

endmodule

// File: tb/tb_vector_reg_file.sv
// tb/tb_vector_reg_file.sv - bench for vector_reg_file: bypass, no-bypass and 5-deep 32-bit instances
module tb_vector_reg_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         rd0_en, rd1_en, wr0_en, wr1_en, rsv_en;
    logic [2:0]   rd0_addr, rd1_addr, wr0_addr, wr1_addr, rsv_addr;
    logic [511:0] wr0_data, wr1_data;

    logic [511:0] a_rd0_data, a_rd1_data, b_rd0_data, b_rd1_data;
    logic [31:0]  c_rd0_data, c_rd1_data;
    logic         a_rd0_valid, a_rd1_valid, b_rd0_valid, b_rd1_valid, c_rd0_valid, c_rd1_valid;
    logic         a_rsv_err, b_rsv_err, c_rsv_err;
    logic [3:0]   a_pend, b_pend;
    logic [4:0]   c_pend;

    vector_reg_file #(.DATA_W(512), .DEPTH(4), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr[1:0]), .rd0_data(a_rd0_data), .rd0_valid(a_rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr[1:0]), .rd1_data(a_rd1_data), .rd1_valid(a_rd1_valid),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr[1:0]), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr[1:0]), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr[1:0]), .rsv_err(a_rsv_err), .pend(a_pend)
    );

    vector_reg_file #(.DATA_W(512), .DEPTH(4), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr[1:0]), .rd0_data(b_rd0_data), .rd0_valid(b_rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr[1:0]), .rd1_data(b_rd1_data), .rd1_valid(b_rd1_valid),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr[1:0]), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr[1:0]), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr[1:0]), .rsv_err(b_rsv_err), .pend(b_pend)
    );

    vector_reg_file #(.DATA_W(32), .DEPTH(5), .BYPASS(1)) u_d5 (
        .clk(clk), .rst(rst),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(c_rd0_data), .rd0_valid(c_rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(c_rd1_data), .rd1_valid(c_rd1_valid),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data[31:0]),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data[31:0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(c_rsv_err), .pend(c_pend)
    );

    logic [511:0] o_data  [3][2];
    logic         o_valid [3][2];
    logic         o_err   [3];
    logic [7:0]   o_pend  [3];

    assign o_data[0][0] = a_rd0_data;             assign o_data[0][1] = a_rd1_data;
    assign o_data[1][0] = b_rd0_data;             assign o_data[1][1] = b_rd1_data;
    assign o_data[2][0] = {480'd0, c_rd0_data};   assign o_data[2][1] = {480'd0, c_rd1_data};
    assign o_valid[0][0] = a_rd0_valid;           assign o_valid[0][1] = a_rd1_valid;
    assign o_valid[1][0] = b_rd0_valid;           assign o_valid[1][1] = b_rd1_valid;
    assign o_valid[2][0] = c_rd0_valid;           assign o_valid[2][1] = c_rd1_valid;
    assign o_err[0] = a_rsv_err;  assign o_err[1] = b_rsv_err;  assign o_err[2] = c_rsv_err;
    assign o_pend[0] = {4'd0, a_pend};
    assign o_pend[1] = {4'd0, b_pend};
    assign o_pend[2] = {3'd0, c_pend};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register contents, pending set and expected outputs per instance.
    logic [511:0] m_mem   [3][8];
    logic [7:0]   m_pend  [3];
    logic [511:0] m_data  [3][2];
    logic         m_valid [3][2];
    logic         m_err   [3];
    bit           started = 1'b0;

    function automatic int inst_depth(input int i);
        return (i == 2) ? 5 : 4;
    endfunction

    function automatic logic [2:0] inst_amask(input int i);
        return (i == 2) ? 3'b111 : 3'b011;
    endfunction

    function automatic logic [511:0] inst_dmask(input int i);
        logic [511:0] m;
        m = '1;
        if (i == 2) m = 512'hFFFF_FFFF;
        return m;
    endfunction

    always @(posedge clk) begin : model
        int depth, w0, w1, rs;
        int ra [2];
        logic en [2];
        logic [2:0] am;
        logic [511:0] dm;
        bit byp;
        if (rst) begin
            started = 1'b1;
            for (int i = 0; i < 3; i++) begin
                for (int r = 0; r < 8; r++) m_mem[i][r] = '0;
                m_pend[i] = '0;
                m_err[i]  = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    m_data[i][p]  = '0;
                    m_valid[i][p] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                depth = inst_depth(i);
                am    = inst_amask(i);
                dm    = inst_dmask(i);
                byp   = (i != 1);
                w0    = int'(wr0_addr & am);
                w1    = int'(wr1_addr & am);
                rs    = int'(rsv_addr & am);
                en[0] = rd0_en;  ra[0] = int'(rd0_addr & am);
                en[1] = rd1_en;  ra[1] = int'(rd1_addr & am);
                for (int p = 0; p < 2; p++) begin
                    if (!en[p]) begin
                        m_valid[i][p] = 1'b0;
                    end else if (ra[p] >= depth) begin
                        m_data[i][p]  = '0;
                        m_valid[i][p] = 1'b1;
                    end else if (byp && wr1_en && w1 == ra[p]) begin
                        m_data[i][p]  = wr1_data & dm;
                        m_valid[i][p] = 1'b1;
                    end else if (byp && wr0_en && w0 == ra[p]) begin
                        m_data[i][p]  = wr0_data & dm;
                        m_valid[i][p] = 1'b1;
                    end else if (!m_pend[i][ra[p]]) begin
                        m_data[i][p]  = m_mem[i][ra[p]];
                        m_valid[i][p] = 1'b1;
                    end else begin
                        m_valid[i][p] = 1'b0;
                    end
                end
                m_err[i] = rsv_en && (rs < depth) && m_pend[i][rs];
                for (int r = 0; r < depth; r++) begin
                    if (rsv_en && rs == r) m_pend[i][r] = 1'b1;
                    else if ((wr0_en && w0 == r) || (wr1_en && w1 == r)) m_pend[i][r] = 1'b0;
                end
                if (wr0_en && w0 < depth) m_mem[i][w0] = wr0_data & dm;
                if (wr1_en && w1 < depth) m_mem[i][w1] = wr1_data & dm;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("model inst%0d rd%0d_data", i, p), o_data[i][p], m_data[i][p]);
                    chk($sformatf("model inst%0d rd%0d_valid", i, p), 512'(o_valid[i][p]), 512'(m_valid[i][p]));
                end
                chk($sformatf("model inst%0d rsv_err", i), 512'(o_err[i]), 512'(m_err[i]));
                chk($sformatf("model inst%0d pend", i), 512'(o_pend[i]), 512'(m_pend[i]));
            end
        end
    end

    task automatic clr();
        rd0_en = 1'b0; rd1_en = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [511:0] pat_a5;

    initial begin
        rst = 1'b1;
        clr();
        rd0_addr = '0; rd1_addr = '0; wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
        wr0_data = '0; wr1_data = '0;
        pat_a5 = {64{8'hA5}};
        tick();
        tick();
        chk("reset pend", 512'(a_pend), 512'd0);
        chk("reset rd0_valid", 512'(a_rd0_valid), 512'd0);
        chk("reset rd0_data", a_rd0_data, 512'd0);
        chk("reset rsv_err", 512'(c_rsv_err), 512'd0);
        rst = 1'b0;

        rd0_en = 1'b1; rd0_addr = 3'd0; rd1_en = 1'b1; rd1_addr = 3'd3;
        tick();
        chk("read after reset rd0_data", a_rd0_data, 512'd0);
        chk("read after reset rd0_valid", 512'(a_rd0_valid), 512'd1);
        chk("read after reset rd1_valid", 512'(a_rd1_valid), 512'd1);

        clr(); wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = pat_a5;
        tick();
        clr(); rd0_en = 1'b1; rd0_addr = 3'd1;
        tick();
        chk("wr/rd addr1 data", a_rd0_data, pat_a5);
        chk("wr/rd addr1 valid", 512'(a_rd0_valid), 512'd1);

        clr(); wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 512'h11;
        wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 512'h22;
        tick();
        clr(); rd0_en = 1'b1; rd0_addr = 3'd2;
        tick();
        chk("wr1 wins", a_rd0_data, 512'h22);

        clr(); wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 512'h33;
        rd0_en = 1'b1; rd0_addr = 3'd2; rd1_en = 1'b1; rd1_addr = 3'd1;
        tick();
        chk("bypass on", a_rd0_data, 512'h33);
        chk("bypass off old value", b_rd0_data, 512'h22);
        chk("rd1 addr1", a_rd1_data, pat_a5);

        clr(); rsv_en = 1'b1; rsv_addr = 3'd3;
        tick();
        chk("rsv pend", 512'(a_pend), 512'b1000);
        clr(); rd1_en = 1'b1; rd1_addr = 3'd3;
        tick();
        chk("pending read valid", 512'(a_rd1_valid), 512'd0);
        chk("pending read held", a_rd1_data, pat_a5);

        clr(); wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 512'h44;
        tick();
        chk("write clears pend", 512'(a_pend), 512'd0);
        clr(); rd1_en = 1'b1; rd1_addr = 3'd3;
        tick();
        chk("read after clear data", a_rd1_data, 512'h44);
        chk("read after clear valid", 512'(a_rd1_valid), 512'd1);

        clr(); rsv_en = 1'b1; rsv_addr = 3'd3;
        tick();
        chk("first rsv no err", 512'(a_rsv_err), 512'd0);
        tick();
        chk("double rsv err", 512'(a_rsv_err), 512'd1);
        chk("double rsv pend", 512'(a_pend), 512'b1000);
        clr();
        tick();
        chk("rsv_err one cycle", 512'(a_rsv_err), 512'd0);

        clr(); rsv_en = 1'b1; rsv_addr = 3'd0; wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 512'h55;
        rd0_en = 1'b1; rd0_addr = 3'd0;
        tick();
        chk("rsv beats write", 512'(a_pend), 512'b1001);
        chk("bypass read of reserved", a_rd0_data, 512'h55);
        chk("nobypass read old", b_rd0_data, 512'd0);
        clr(); wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 512'h66; rd0_en = 1'b1; rd0_addr = 3'd0;
        tick();
        chk("bypass pending hit data", a_rd0_data, 512'h66);
        chk("nobypass pending invalid", 512'(b_rd0_valid), 512'd0);
        chk("pend after write", 512'(a_pend), 512'b1000);

        for (int k = 0; k < 5; k++) begin
            clr(); wr0_en = 1'b1; wr0_addr = 3'(k); wr0_data = 512'(32'hC0DE_0000 + k);
            tick();
        end
        clr(); wr0_en = 1'b1; wr0_addr = 3'd7; wr0_data = 512'hDEAD;
        tick();
        for (int k = 0; k < 5; k++) begin
            clr(); rd0_en = 1'b1; rd0_addr = 3'(k); rd1_en = 1'b1; rd1_addr = 3'(4 - k);
            tick();
            chk($sformatf("d5 rd0 addr%0d", k), 512'(c_rd0_data), 512'(32'hC0DE_0000 + k));
            chk($sformatf("d5 rd1 addr%0d", 4 - k), 512'(c_rd1_data), 512'(32'hC0DE_0000 + 4 - k));
        end
        clr(); rd0_en = 1'b1; rd0_addr = 3'd7;
        tick();
        chk("d5 out-of-range data", 512'(c_rd0_data), 512'd0);
        chk("d5 out-of-range valid", 512'(c_rd0_valid), 512'd1);

        clr(); rsv_en = 1'b1; rsv_addr = 3'd4;
        tick();
        rst = 1'b1; rd0_en = 1'b1; rd0_addr = 3'd1; rd1_en = 1'b1; rd1_addr = 3'd2; rsv_en = 1'b0;
        tick();
        chk("mid reset rd0_valid", 512'(c_rd0_valid), 512'd0);
        chk("mid reset rd1_valid", 512'(a_rd1_valid), 512'd0);
        chk("mid reset pend", 512'(c_pend), 512'd0);
        rst = 1'b0;
        clr(); rd0_en = 1'b1; rd0_addr = 3'd4;
        tick();
        chk("after reset d5 addr4", 512'(c_rd0_data), 512'd0);

        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            rd0_en   = $urandom_range(0, 1) == 1;
            rd1_en   = $urandom_range(0, 1) == 1;
            wr0_en   = $urandom_range(0, 1) == 1;
            wr1_en   = $urandom_range(0, 1) == 1;
            rsv_en   = $urandom_range(0, 3) == 0;
            rd0_addr = 3'($urandom_range(0, 7));
            rd1_addr = 3'($urandom_range(0, 7));
            wr0_addr = 3'($urandom_range(0, 7));
            wr1_addr = 3'($urandom_range(0, 7));
            rsv_addr = 3'($urandom_range(0, 7));
            for (int k = 0; k < 16; k++) begin
                wr0_data[k*32 +: 32] = $urandom;
                wr1_data[k*32 +: 32] = $urandom;
            end
            tick();
        end
        rst = 1'b0;
        clr();
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
